// File: rtl/regs_pkg.sv
// Shared register-file types and constants, also used by the write-register select mux.
package regs_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;
  localparam reg_idx_t REG_RA   = 5'd31;
endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register, set at issue, cleared at writeback.
module reg_scoreboard #(
  parameter int ADDR_W  = regs_pkg::ADDR_W,
  parameter bit FORWARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic              busy_a,
  output logic              busy_b
);
  localparam int NREG = 1 << ADDR_W;

  logic [NREG-1:0] pending, pending_nxt;
  logic            wb_hit_a, wb_hit_b;

  // Clear before set so a same-edge issue to the retiring index keeps the bit.
  always_comb begin
    pending_nxt = pending;
    if (wb_en && wb_addr != '0)
      pending_nxt[wb_addr] = 1'b0;
    if (iss_valid && iss_addr != '0)
      pending_nxt[iss_addr] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) pending <= '0;
    else     pending <= pending_nxt;
  end

  assign wb_hit_a = FORWARD && wb_en && (wb_addr == rd_addr_a);
  assign wb_hit_b = FORWARD && wb_en && (wb_addr == rd_addr_b);
  assign busy_a   = pending[rd_addr_a] && !wb_hit_a;
  assign busy_b   = pending[rd_addr_b] && !wb_hit_b;
endmodule

// File: rtl/regs_wb.sv
// MIPS architectural register file: 2 combinational reads, 1 write, optional bypass, scoreboard.
module regs_wb
  import regs_pkg::*;
#(
  parameter int DATA_W  = regs_pkg::DATA_W,
  parameter int ADDR_W  = regs_pkg::ADDR_W,
  parameter bit FORWARD = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B,
  input  logic              L_S,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_addr,
  output logic              busy_A,
  output logic              busy_B,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  localparam int NREG = 1 << ADDR_W;

  // Register 0 is hardwired; storage starts at index 1.
  logic [DATA_W-1:0] regs [NREG-1:1];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) regs[i] <= '0;
    end else if (L_S && Wt_addr != '0) begin
      regs[Wt_addr] <= Wt_data;
    end
  end

  always_comb begin
    rdata_A = '0;
    if (R_addr_A != '0) begin
      if (FORWARD && L_S && Wt_addr == R_addr_A) rdata_A = Wt_data;
      else                                       rdata_A = regs[R_addr_A];
    end
  end

  always_comb begin
    rdata_B = '0;
    if (R_addr_B != '0) begin
      if (FORWARD && L_S && Wt_addr == R_addr_B) rdata_B = Wt_data;
      else                                       rdata_B = regs[R_addr_B];
    end
  end

  // Debug port shows committed state only, never the in-flight write.
  always_comb begin
    dbg_data = '0;
    if (dbg_addr != '0) dbg_data = regs[dbg_addr];
  end

  reg_scoreboard #(
    .ADDR_W  (ADDR_W),
    .FORWARD (FORWARD)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .wb_en     (L_S),
    .wb_addr   (Wt_addr),
    .rd_addr_a (R_addr_A),
    .rd_addr_b (R_addr_B),
    .busy_a    (busy_A),
    .busy_b    (busy_B)
  );
endmodule

// File: tb/tb_regs_wb.sv
// Directed bench for regs_wb with FORWARD=1 and hand-computed expectations.
module tb_regs_wb;
  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  R_addr_A, R_addr_B, Wt_addr, iss_addr, dbg_addr;
  logic [31:0] rdata_A, rdata_B, Wt_data, dbg_data;
  logic        L_S, iss_valid, busy_A, busy_B;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  regs_wb #(.DATA_W(32), .ADDR_W(5), .FORWARD(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .R_addr_A  (R_addr_A),
    .R_addr_B  (R_addr_B),
    .rdata_A   (rdata_A),
    .rdata_B   (rdata_B),
    .L_S       (L_S),
    .Wt_addr   (Wt_addr),
    .Wt_data   (Wt_data),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .busy_A    (busy_A),
    .busy_B    (busy_B),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs then change away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; L_S = 1'b0; iss_valid = 1'b0;
    R_addr_A = '0; R_addr_B = '0; Wt_addr = '0; iss_addr = '0; dbg_addr = '0;
    Wt_data = '0;
    tick(); tick();
    rst = 1'b0;
    R_addr_A = 5'd5; R_addr_B = 5'd31; dbg_addr = 5'd5;
    #1;
    chk("rst_rdA", rdata_A, 32'h0);
    chk("rst_rdB", rdata_B, 32'h0);
    chk("rst_dbg", dbg_data, 32'h0);
    chk("rst_busy", {30'h0, busy_A, busy_B}, 32'h0);

    // Plain write, visible next cycle on read and debug ports
    L_S = 1'b1; Wt_addr = 5'd5; Wt_data = 32'hDEADBEEF;
    tick();
    L_S = 1'b0;
    #1;
    chk("wr5_rdA", rdata_A, 32'hDEADBEEF);
    chk("wr5_dbg", dbg_data, 32'hDEADBEEF);

    // Writes to r0 are discarded
    L_S = 1'b1; Wt_addr = 5'd0; Wt_data = 32'hFFFFFFFF; R_addr_B = 5'd0; dbg_addr = 5'd0;
    #1;
    chk("wr0_rdB_same", rdata_B, 32'h0);
    chk("wr0_busyB_same", {31'h0, busy_B}, 32'h0);
    tick();
    L_S = 1'b0;
    #1;
    chk("wr0_rdB", rdata_B, 32'h0);
    chk("wr0_busyB", {31'h0, busy_B}, 32'h0);
    chk("wr0_dbg", dbg_data, 32'h0);

    // Same-cycle bypass; debug still shows committed value
    R_addr_A = 5'd7; dbg_addr = 5'd7;
    L_S = 1'b1; Wt_addr = 5'd7; Wt_data = 32'h1234;
    #1;
    chk("byp_rdA", rdata_A, 32'h1234);
    chk("byp_dbg_old", dbg_data, 32'h0);
    tick();
    L_S = 1'b0;
    #1;
    chk("byp_dbg_new", dbg_data, 32'h1234);

    // Issue to r9, busy next cycle, held, dropped in writeback cycle
    R_addr_A = 5'd9;
    iss_valid = 1'b1; iss_addr = 5'd9;
    #1;
    chk("iss_busy_before", {31'h0, busy_A}, 32'h0);
    tick();
    iss_valid = 1'b0;
    #1;
    chk("iss_busy_c1", {31'h0, busy_A}, 32'h1);
    tick();
    chk("iss_busy_c2", {31'h0, busy_A}, 32'h1);
    tick();
    chk("iss_busy_c3", {31'h0, busy_A}, 32'h1);
    L_S = 1'b1; Wt_addr = 5'd9; Wt_data = 32'h99;
    #1;
    chk("wb_busy_drop", {31'h0, busy_A}, 32'h0);
    chk("wb_rdA_byp", rdata_A, 32'h99);
    tick();
    L_S = 1'b0;
    #1;
    chk("wb_busy_after", {31'h0, busy_A}, 32'h0);
    chk("wb_rdA_commit", rdata_A, 32'h99);

    // Same-edge issue and writeback to r9: set wins, data still written
    iss_valid = 1'b1; iss_addr = 5'd9;
    L_S = 1'b1; Wt_addr = 5'd9; Wt_data = 32'h55;
    dbg_addr = 5'd9;
    tick();
    iss_valid = 1'b0; L_S = 1'b0;
    #1;
    chk("setclr_busy", {31'h0, busy_A}, 32'h1);
    chk("setclr_rdA", rdata_A, 32'h55);
    chk("setclr_dbg", dbg_data, 32'h55);

    // r31 = A5A5A5A5, then pending on 3 and 31 (9 still pending)
    L_S = 1'b1; Wt_addr = 5'd31; Wt_data = 32'hA5A5A5A5;
    tick();
    L_S = 1'b0;
    iss_valid = 1'b1; iss_addr = 5'd3;
    tick();
    iss_addr = 5'd31;
    tick();
    iss_valid = 1'b0;
    R_addr_A = 5'd3; R_addr_B = 5'd31; dbg_addr = 5'd31;
    #1;
    chk("pre_rst_busy3", {31'h0, busy_A}, 32'h1);
    chk("pre_rst_busy31", {31'h0, busy_B}, 32'h1);
    chk("pre_rst_r31", rdata_B, 32'hA5A5A5A5);
    chk("pre_rst_dbg31", dbg_data, 32'hA5A5A5A5);
    R_addr_A = 5'd9;
    #1;
    chk("pre_rst_busy9", {31'h0, busy_A}, 32'h1);

    // Reset dominates a concurrent write to r4
    rst = 1'b1; L_S = 1'b1; Wt_addr = 5'd4; Wt_data = 32'h77;
    tick();
    rst = 1'b0; L_S = 1'b0;
    R_addr_A = 5'd3; R_addr_B = 5'd31; dbg_addr = 5'd4;
    #1;
    chk("post_rst_busy3", {31'h0, busy_A}, 32'h0);
    chk("post_rst_busy31", {31'h0, busy_B}, 32'h0);
    chk("post_rst_r31", rdata_B, 32'h0);
    chk("post_rst_r4", dbg_data, 32'h0);
    R_addr_A = 5'd9; R_addr_B = 5'd5; dbg_addr = 5'd7;
    #1;
    chk("post_rst_busy9", {31'h0, busy_A}, 32'h0);
    chk("post_rst_r5", rdata_B, 32'h0);
    chk("post_rst_r7", dbg_data, 32'h0);
    chk("post_rst_r9", rdata_A, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/regs_wb.md
# regs_wb

Architectural register file for the MIPS core: 32 × 32-bit registers with two combinational read ports, one synchronous write port, same-cycle write-to-read bypass, and a pending-write scoreboard. It sits directly downstream of the 4:1 5-bit write-register select multiplexer (rt / rd / $31 / spare). That mux's output drives `Wt_addr` here, and this block provides the operands for the ALU stage.

## Interface
Parameters:
- `DATA_W`, 32, register width
- `ADDR_W`, 5, register index width; must equal the write-select mux width
- `FORWARD`, 1, 1 = same-cycle write data bypasses to read ports and clears busy; 0 = no bypass

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `R_addr_A`  in  ADDR_W  read port A index (rs)
- `R_addr_B`  in  ADDR_W  read port B index (rt)
- `rdata_A`  out  DATA_W  port A data, combinational
- `rdata_B`  out  DATA_W  port B data, combinational
- `L_S`  in  1  write enable
- `Wt_addr`  in  ADDR_W  write index, from the write-register select mux
- `Wt_data`  in  DATA_W  write data
- `iss_valid`  in  1  an instruction that will write `iss_addr` has issued
- `iss_addr`  in  ADDR_W  destination of the issuing instruction
- `busy_A`  out  1  `R_addr_A` has an outstanding write
- `busy_B`  out  1  `R_addr_B` has an outstanding write
- `dbg_addr`  in  ADDR_W  debug/VGA read index
- `dbg_data`  out  DATA_W  debug read data; no bypass

## Operation
- Storage: `regs[1..31]`. Register 0 is not stored and reads as 0 on every port.
- Write: at a rising edge with `!rst && L_S && Wt_addr != 0`, `regs[Wt_addr] <= Wt_data`. Writes to index 0 are discarded.
- Read: `rdata_X = 0` if `R_addr_X == 0`.
  - Else, if `FORWARD && L_S && Wt_addr == R_addr_X`, `rdata_X = Wt_data`.
  - Else, `rdata_X = regs[R_addr_X]`.
- Scoreboard: `pending[31:0]`; bit 0 is constant 0.
  - Set on `iss_valid && iss_addr != 0`.
  - Cleared on `L_S && Wt_addr != 0`.
- Set and clear of the same index in one edge: set wins. The new issue is younger than the retiring write.
- Issue to an index that is already pending: the bit stays 1. One outstanding write per register is the pipeline's contract; the scoreboard does not count.
- `busy_X = pending[R_addr_X]`, except that with `FORWARD=1` it is 0 when `L_S && Wt_addr == R_addr_X` in the same cycle.
- Reset: at an edge with `rst=1`, all `regs` are cleared to 0 and `pending` is cleared to 0. Reset dominates any write or issue in that cycle.
- Outputs after reset:
  - `rdata_A`, `rdata_B`, `dbg_data` = 0, unless bypassed.
  - `busy_A`, `busy_B` = 0.
- Reset mid-operation abandons all outstanding writes; no stale busy bit survives.

## Timing
- Read latency 0 (combinational from the address and state).
- Write latency 1 edge. With `FORWARD=1` the data is visible the same cycle; with `FORWARD=0` it is visible from the next cycle.
- Issue-to-busy: 1 edge. The busy bit appears the cycle after `iss_valid`.
- Writeback-to-not-busy: same cycle with `FORWARD=1`, otherwise the next cycle.
- `dbg_data` always reflects committed state only.

## Structure
- Shared package `regs_pkg` holds:
  - `DATA_W`, `ADDR_W`
  - `REG_ZERO = 5'd0`, `REG_RA = 5'd31`
  - the `reg_idx_t` typedef, also used by the write-select mux
- One sub-module, `reg_scoreboard`. It contains `pending`, the set/clear/reset logic, and the two busy lookups, so the pipeline control unit can reuse it standalone.
- The register array and the bypass muxes stay in `regs_wb`.

## Test plan
- Reset, then write `Wt_addr=5, Wt_data=32'hDEADBEEF`. Next cycle, `R_addr_A=5` gives `rdata_A=32'hDEADBEEF`, and `dbg_addr=5` gives the same value.
- Write `Wt_addr=0, Wt_data=32'hFFFFFFFF`. Then `R_addr_B=0` gives `rdata_B=0`; `busy_B=0` throughout.
- With `FORWARD=1`, write `Wt_addr=7, Wt_data=32'h1234` while `R_addr_A=7`. The same cycle gives `rdata_A=32'h1234`; `dbg_data` for index 7 still shows the old value 0.
- Issue `iss_addr=9`; next cycle `busy_A=1` for `R_addr_A=9`. Hold 3 cycles, then write back to 9: `busy_A` drops in the writeback cycle (`FORWARD=1`).
- Same edge `iss_addr=9` and `L_S, Wt_addr=9`: `pending[9]` remains 1, and `regs[9]` takes `Wt_data`.
- Pending bits on 3, 9 and 31, and `regs[31]=32'hA5A5A5A5`. Assert `rst` for one cycle together with `L_S, Wt_addr=4`: all busy outputs are 0, every register reads 0, and `regs[4]` is unchanged at 0.
